// File: rtl/posit_to_float_arbiter.sv
// posit_to_float_arbiter
// Shares a single posit(n,es) -> IEEE binary64 converter among NUM_REQ
// requesters. Round-robin grant, two pipeline stages (capture, convert),
// valid/ready on both sides, results tagged with the requester index and
// returned in grant order.
// Optional build macro: P2F_ARB_STATS_EN adds saturating class counters
// (zero, NaR, regular conversions) that only rst_i clears.
module posit_to_float_arbiter #(
  parameter int n        = 16,
  parameter int es       = 1,
  parameter int NUM_REQ  = 4,
  parameter int FP_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*n-1:0]          req_operand_i,
  input  logic                          flush_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [FP_WIDTH-1:0]           res_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    res_id_o,
  output logic                          res_special_o,
  output logic                          busy_o
`ifdef P2F_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_zero_cnt_o,
  output logic [15:0]                   stat_nar_cnt_o,
  output logic [31:0]                   stat_conv_cnt_o
`endif
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam logic [n-1:0]  POSIT_NAR = {1'b1, {(n-1){1'b0}}};
  localparam logic [63:0]   F64_QNAN  = 64'h7FF8_0000_0000_0000;

  // Posit -> binary64 for every non-zero, non-NaR pattern. The fraction is
  // at most n-1 bits, so for n<=32 it always fits the 52-bit field exactly.
  function automatic logic [63:0] posit_to_f64(input logic [n-1:0] p);
    logic [n-1:0] mag;
    logic [n-2:0] body;
    logic [n-2:0] sh;
    logic [n-2:0] fr;
    logic         rbit;
    logic         in_run;
    int           run;
    int           k;
    int           e;
    int           scale;
    logic [10:0]  bexp;
    logic [51:0]  frac52;
    mag    = p[n-1] ? (~p + 1'b1) : p;
    body   = mag[n-2:0];
    rbit   = body[n-2];
    run    = 0;
    in_run = 1'b1;
    for (int i = n - 2; i >= 0; i--) begin
      if (in_run && (body[i] == rbit)) run = run + 1;
      else in_run = 1'b0;
    end
    k = rbit ? (run - 1) : -run;
    // Drop the regime run and its terminating bit; exponent then fraction follow.
    sh = body << (run + 1);
    e  = 0;
    for (int j = 0; j < es; j++) e = (e * 2) + int'(sh[n-2-j]);
    fr     = sh << es;
    scale  = (k * (1 << es)) + e;
    bexp   = 11'(scale + 1023);
    frac52 = '0;
    frac52[51 -: (n-1)] = fr;
    return {p[n-1], bexp, frac52};
  endfunction

`ifdef P2F_ARB_STATS_EN
  // Saturating increments for the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction
`endif

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_found;
  logic                adv1;
  logic                accept;
  logic                hs;
  logic [n-1:0]        cap_op;
  logic [ID_WIDTH-1:0] rr_next;

  logic [n-1:0]        op_p0;
  logic [ID_WIDTH-1:0] id_p0;
  logic                vld_p0;

  logic [63:0]         res_data_p1;
  logic [ID_WIDTH-1:0] res_id_p1;
  logic                res_special_p1;
  logic                vld_p1;

  logic                conv_zero;
  logic                conv_nar;
  logic [63:0]         conv_data;

  // Round-robin grant: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!grant_found && req_valid_i[(int'(rr_ptr) + off) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant[(int'(rr_ptr) + off) % NUM_REQ] = 1'b1;
        grant_id = ID_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  // S1 can take S0 when the output is empty or being consumed; reset and
  // flush both suppress new captures.
  assign adv1        = vld_p0 & (~vld_p1 | res_ready_i);
  assign accept      = ~rst_i & ~flush_i & (~vld_p0 | adv1);
  assign req_ready_o = grant & {NUM_REQ{accept}};
  assign hs          = |req_ready_o;
  assign cap_op      = req_operand_i[grant_id*n +: n];
  assign rr_next     = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Control state: stage valids and arbitration pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      if (hs) begin
        vld_p0 <= 1'b1;
        rr_ptr <= rr_next;
      end else if (adv1) begin
        vld_p0 <= 1'b0;
      end
      if (adv1) vld_p1 <= 1'b1;
      else if (res_ready_i) vld_p1 <= 1'b0;
    end
  end

  // ---- Stage 0: capture granted operand and its requester index ----
  // Operand capture on handshake.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      op_p0 <= cap_op;
      id_p0 <= grant_id;
    end
  end

  // ---- Stage 1: convert and hold result until consumed ----
  // Combinational conversion of the S0 operand, specials handled first.
  always_comb begin
    conv_zero = (op_p0 == '0);
    conv_nar  = (op_p0 == POSIT_NAR);
    if (conv_zero)     conv_data = '0;
    else if (conv_nar) conv_data = F64_QNAN;
    else               conv_data = posit_to_f64(op_p0);
  end

  // Result registers; cleared on reset so no stale value is ever visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_data_p1    <= '0;
      res_id_p1      <= '0;
      res_special_p1 <= 1'b0;
    end else if (adv1 && !flush_i) begin
      res_data_p1    <= conv_data;
      res_id_p1      <= id_p0;
      res_special_p1 <= conv_zero | conv_nar;
    end
  end

  assign res_valid_o   = vld_p1;
  assign res_data_o    = res_data_p1;
  assign res_id_o      = res_id_p1;
  assign res_special_o = res_special_p1;
  assign busy_o        = vld_p0 | vld_p1;

`ifdef P2F_ARB_STATS_EN
  logic [15:0] zero_cnt;
  logic [15:0] nar_cnt;
  logic [31:0] conv_cnt;

  // Per-class conversion counters; conv counts regular (non-special) values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      zero_cnt <= '0;
      nar_cnt  <= '0;
      conv_cnt <= '0;
    end else if (adv1 && !flush_i) begin
      if (conv_zero)     zero_cnt <= sat_inc16(zero_cnt);
      else if (conv_nar) nar_cnt  <= sat_inc16(nar_cnt);
      else               conv_cnt <= sat_inc32(conv_cnt);
    end
  end

  assign stat_zero_cnt_o = zero_cnt;
  assign stat_nar_cnt_o  = nar_cnt;
  assign stat_conv_cnt_o = conv_cnt;
`endif

endmodule
